// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file for the MIPS datapath.
// Two combinational read ports, two synchronous write ports (port 0 = ALU
// result, port 1 = load return), optional write-to-read bypass, optional
// hardwired-zero register 0, and a per-register busy scoreboard that decode
// sets on issue and writeback clears.
module regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [ADDR_W-1:0] RdAddr1,
   input  logic [ADDR_W-1:0] RdAddr2,
   output logic [DATA_W-1:0] RdData1,
   output logic [DATA_W-1:0] RdData2,
   output logic              RdBusy1,
   output logic              RdBusy2,
   input  logic              WrEn0,
   input  logic              WrEn1,
   input  logic [ADDR_W-1:0] WrAddr0,
   input  logic [ADDR_W-1:0] WrAddr1,
   input  logic [DATA_W-1:0] WrData0,
   input  logic [DATA_W-1:0] WrData1,
   input  logic              IssueEn,
   input  logic [ADDR_W-1:0] IssueAddr,
   output logic              AnyBusy
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic              wrLive0;
   logic              wrLive1;

   // While reset is held the write ports must not leak onto the read
   // paths through the bypass, so the forwarding enables are gated by RST.
   assign wrLive0 = WrEn0 & RST;
   assign wrLive1 = WrEn1 & RST;

   // Forwarded/stored read value: zero register first, then load-return
   // port, then ALU port, then storage.
   function automatic logic [DATA_W-1:0] readData(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] d;
      d = regs[a];
      if (BYPASS != 0) begin
         if (wrLive1 && (WrAddr1 == a)) begin
            d = WrData1;
         end else if (wrLive0 && (WrAddr0 == a)) begin
            d = WrData0;
         end
      end
      if ((ZERO_REG != 0) && (a == '0)) begin
         d = '0;
      end
      return d;
   endfunction

   // Busy as seen by a reader: with bypass, a writeback landing this cycle
   // already satisfies the reader, so it masks the registered busy bit.
   function automatic logic readBusy(input logic [ADDR_W-1:0] a);
      logic b;
      b = busy[a];
      if (BYPASS != 0) begin
         if ((wrLive1 && (WrAddr1 == a)) || (wrLive0 && (WrAddr0 == a))) begin
            b = 1'b0;
         end
      end
      return b;
   endfunction

   // Storage and scoreboard update; port 1 wins a same-address collision
   // and a new issue supersedes a same-cycle writeback on the busy bit.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int r = 0; r < DEPTH; r++) begin
            regs[r] <= '0;
         end
         busy <= '0;
      end else begin
         for (int r = 0; r < DEPTH; r++) begin
            if (!((ZERO_REG != 0) && (r == 0))) begin
               if (WrEn1 && (WrAddr1 == ADDR_W'(r))) begin
                  regs[r] <= WrData1;
               end else if (WrEn0 && (WrAddr0 == ADDR_W'(r))) begin
                  regs[r] <= WrData0;
               end
               if (IssueEn && (IssueAddr == ADDR_W'(r))) begin
                  busy[r] <= 1'b1;
               end else if ((WrEn1 && (WrAddr1 == ADDR_W'(r))) ||
                            (WrEn0 && (WrAddr0 == ADDR_W'(r)))) begin
                  busy[r] <= 1'b0;
               end
            end
         end
      end
   end

   // Purely combinational read ports driven from addresses, write inputs
   // and state.
   always_comb begin
      RdData1 = readData(RdAddr1);
      RdData2 = readData(RdAddr2);
      RdBusy1 = readBusy(RdAddr1);
      RdBusy2 = readBusy(RdAddr2);
      AnyBusy = |busy;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp.
// Instance A uses the default build (32-bit, 32 regs, zero reg, bypass);
// instance B is a 16-bit, 8-register build with no zero reg and no bypass,
// fed from the low bits of the same stimulus so address wrap is exercised.
module tb_regfile_mp;

   localparam int A_RD1  = 0;
   localparam int A_RD2  = 1;
   localparam int A_BSY1 = 2;
   localparam int A_BSY2 = 3;
   localparam int A_ANY  = 4;
   localparam int B_RD1  = 5;
   localparam int B_RD2  = 6;
   localparam int B_BSY1 = 7;
   localparam int B_ANY  = 8;

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] exp;
   } expT;

   logic        clk;
   logic        rst;
   logic [4:0]  rdAddr1;
   logic [4:0]  rdAddr2;
   logic        wrEn0;
   logic        wrEn1;
   logic [4:0]  wrAddr0;
   logic [4:0]  wrAddr1;
   logic [31:0] wrData0;
   logic [31:0] wrData1;
   logic        issueEn;
   logic [4:0]  issueAddr;

   logic [31:0] aRdData1;
   logic [31:0] aRdData2;
   logic        aRdBusy1;
   logic        aRdBusy2;
   logic        aAnyBusy;
   logic [15:0] bRdData1;
   logic [15:0] bRdData2;
   logic        bRdBusy1;
   logic        bRdBusy2;
   logic        bAnyBusy;

   expT         expQ [$];
   int          checks;
   int          errors;
   logic        done;

   logic [15:0] pat [8] = '{16'h5A5A, 16'h4B4B, 16'h7878, 16'h6969,
                            16'h1E1E, 16'h0F0F, 16'h3C3C, 16'h2D2D};

   regfile_mp dutA (
      .CLK(clk), .RST(rst),
      .RdAddr1(rdAddr1), .RdAddr2(rdAddr2),
      .RdData1(aRdData1), .RdData2(aRdData2),
      .RdBusy1(aRdBusy1), .RdBusy2(aRdBusy2),
      .WrEn0(wrEn0), .WrEn1(wrEn1),
      .WrAddr0(wrAddr0), .WrAddr1(wrAddr1),
      .WrData0(wrData0), .WrData1(wrData1),
      .IssueEn(issueEn), .IssueAddr(issueAddr),
      .AnyBusy(aAnyBusy)
   );

   regfile_mp #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) dutB (
      .CLK(clk), .RST(rst),
      .RdAddr1(rdAddr1[2:0]), .RdAddr2(rdAddr2[2:0]),
      .RdData1(bRdData1), .RdData2(bRdData2),
      .RdBusy1(bRdBusy1), .RdBusy2(bRdBusy2),
      .WrEn0(wrEn0), .WrEn1(wrEn1),
      .WrAddr0(wrAddr0[2:0]), .WrAddr1(wrAddr1[2:0]),
      .WrData0(wrData0[15:0]), .WrData1(wrData1[15:0]),
      .IssueEn(issueEn), .IssueAddr(issueAddr[2:0]),
      .AnyBusy(bAnyBusy)
   );

   // Free-running 10-time-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] actual(input int sel);
      case (sel)
         A_RD1:   return aRdData1;
         A_RD2:   return aRdData2;
         A_BSY1:  return {31'd0, aRdBusy1};
         A_BSY2:  return {31'd0, aRdBusy2};
         A_ANY:   return {31'd0, aAnyBusy};
         B_RD1:   return {16'd0, bRdData1};
         B_RD2:   return {16'd0, bRdData2};
         B_BSY1:  return {31'd0, bRdBusy1};
         B_ANY:   return {31'd0, bAnyBusy};
         default: return 32'hxxxxxxxx;
      endcase
   endfunction

   // Drive one cycle of stimulus just after the rising edge.
   task automatic applyStimulus(input logic we0, input logic [4:0] wa0, input logic [31:0] wd0,
                                input logic we1, input logic [4:0] wa1, input logic [31:0] wd1,
                                input logic ie, input logic [4:0] ia,
                                input logic [4:0] ra1, input logic [4:0] ra2);
      @(posedge clk);
      #1;
      wrEn0 = we0; wrAddr0 = wa0; wrData0 = wd0;
      wrEn1 = we1; wrAddr1 = wa1; wrData1 = wd1;
      issueEn = ie; issueAddr = ia;
      rdAddr1 = ra1; rdAddr2 = ra2;
   endtask

   task automatic idle(input logic [4:0] ra1, input logic [4:0] ra2);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, ra1, ra2);
   endtask

   // Queue an expected value for the monitor to compare this cycle.
   task automatic checkOutput(input string name, input int sel, input logic [31:0] exp);
      expT e;
      e.name = name;
      e.sel  = sel;
      e.exp  = exp;
      expQ.push_back(e);
   endtask

   // Monitor: at each falling edge compare every pending expectation,
   // and emit the summary once stimulus has finished.
   initial begin
      expT         e;
      logic [31:0] act;
      checks = 0;
      errors = 0;
      forever begin
         @(negedge clk);
         while (expQ.size() > 0) begin
            e = expQ.pop_front();
            act = actual(e.sel);
            checks++;
            if (act !== e.exp) begin
               errors++;
               $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
            end
         end
         if (done) begin
            if (expQ.size() != 0) begin
               errors++;
               $display("[TB] FAIL drain: %0d expectations left unchecked", expQ.size());
            end
            if (checks < 12) begin
               errors++;
               $display("[TB] FAIL coverage: only %0d checks executed", checks);
            end
            if (errors == 0) begin
               $display("[TB] PASS all %0d checks", checks);
            end else begin
               $display("[TB] FAIL %0d errors", errors);
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
         end
      end
   end

   // Watchdog so the bench can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed stimulus with hand-computed expectations.
   initial begin
      done = 1'b0;
      rst = 1'b0;
      wrEn0 = 1'b0; wrAddr0 = 5'd0; wrData0 = 32'h0;
      wrEn1 = 1'b0; wrAddr1 = 5'd0; wrData1 = 32'h0;
      issueEn = 1'b0; issueAddr = 5'd0;
      rdAddr1 = 5'd5; rdAddr2 = 5'd3;

      @(posedge clk);
      #1;
      checkOutput("resetRdA", A_RD1, 32'h0);
      checkOutput("resetAnyA", A_ANY, 32'h0);
      checkOutput("resetBusyA", A_BSY1, 32'h0);
      checkOutput("resetRdB", B_RD1, 32'h0);
      @(posedge clk);
      #1 rst = 1'b1;

      applyStimulus(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5, 5'd0);
      checkOutput("bypassR5", A_RD1, 32'h1234);
      checkOutput("busyR5Same", A_BSY1, 32'h0);
      idle(5'd5, 5'd0);
      checkOutput("storedR5", A_RD1, 32'h1234);
      checkOutput("busyR5Next", A_BSY1, 32'h1);
      checkOutput("anyR5", A_ANY, 32'h1);
      applyStimulus(1'b1, 5'd5, 32'hDEAD, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0);
      #1 rst = 1'b0;
      checkOutput("midRstRd", A_RD1, 32'h0);
      checkOutput("midRstAny", A_ANY, 32'h0);
      checkOutput("midRstBusy", A_BSY1, 32'h0);
      idle(5'd5, 5'd0);
      rst = 1'b1;
      checkOutput("postRstRd", A_RD1, 32'h0);

      applyStimulus(1'b1, 5'd7, 32'hAAAA, 1'b1, 5'd7, 32'h5555, 1'b0, 5'd0, 5'd7, 5'd7);
      checkOutput("collideRd1", A_RD1, 32'h5555);
      checkOutput("collideRd2", A_RD2, 32'h5555);
      idle(5'd7, 5'd6);
      checkOutput("collideStored", A_RD1, 32'h5555);
      checkOutput("untouchedR6", A_RD2, 32'h0);

      applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0);
      checkOutput("zeroRd1", A_RD1, 32'h0);
      checkOutput("zeroRd2", A_RD2, 32'h0);
      checkOutput("zeroBusy", A_BSY1, 32'h0);
      checkOutput("zeroAny", A_ANY, 32'h0);
      idle(5'd0, 5'd0);
      checkOutput("zeroRdNext", A_RD1, 32'h0);
      checkOutput("zeroBusyNext", A_BSY1, 32'h0);
      checkOutput("zeroAnyNext", A_ANY, 32'h0);

      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd0);
      checkOutput("issueSameBusy", A_BSY1, 32'h0);
      checkOutput("issueSameAny", A_ANY, 32'h0);
      idle(5'd3, 5'd0);
      checkOutput("issueBusy", A_BSY1, 32'h1);
      checkOutput("issueAny", A_ANY, 32'h1);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h42, 1'b0, 5'd0, 5'd3, 5'd0);
      checkOutput("wbBusyMask", A_BSY1, 32'h0);
      checkOutput("wbBypass", A_RD1, 32'h42);
      checkOutput("wbAnyStill", A_ANY, 32'h1);
      idle(5'd3, 5'd0);
      checkOutput("wbAnyClear", A_ANY, 32'h0);
      checkOutput("wbStored", A_RD1, 32'h42);

      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0);
      applyStimulus(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0);
      checkOutput("raceRd", A_RD1, 32'h99);
      checkOutput("raceBusyMask", A_BSY1, 32'h0);
      idle(5'd9, 5'd0);
      checkOutput("raceBusyKept", A_BSY1, 32'h1);
      checkOutput("raceStored", A_RD1, 32'h99);
      checkOutput("raceAny", A_ANY, 32'h1);
      applyStimulus(1'b1, 5'd9, 32'h100, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0);
      checkOutput("raceClrBusy", A_BSY1, 32'h0);
      checkOutput("raceClrRd", A_RD1, 32'h100);

      applyStimulus(1'b1, 5'd10, 32'h10, 1'b1, 5'd11, 32'h11, 1'b1, 5'd12, 5'd10, 5'd11);
      checkOutput("dualRd1", A_RD1, 32'h10);
      checkOutput("dualRd2", A_RD2, 32'h11);
      checkOutput("dualAny", A_ANY, 32'h0);
      idle(5'd10, 5'd12);
      checkOutput("dualStored", A_RD1, 32'h10);
      checkOutput("busy2Set", A_BSY2, 32'h1);
      checkOutput("busy2Any", A_ANY, 32'h1);
      applyStimulus(1'b1, 5'd12, 32'hC, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd11, 5'd12);
      checkOutput("dualStored2", A_RD1, 32'h11);
      checkOutput("busy2Mask", A_BSY2, 32'h0);
      checkOutput("port0Bypass2", A_RD2, 32'hC);
      idle(5'd0, 5'd0);
      checkOutput("busy2AnyClr", A_ANY, 32'h0);

      @(posedge clk);
      #1 rst = 1'b0;
      checkOutput("bRstRd", B_RD1, 32'h0);
      checkOutput("bRstAny", B_ANY, 32'h0);
      @(posedge clk);
      #1 rst = 1'b1;

      applyStimulus(1'b1, 5'd7, 32'h1111, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0);
      checkOutput("bNoBypass", B_RD1, 32'h0);
      applyStimulus(1'b1, 5'd7, 32'hAAAA, 1'b1, 5'd7, 32'h5555, 1'b0, 5'd0, 5'd7, 5'd0);
      checkOutput("bCollideOld", B_RD1, 32'h1111);
      idle(5'd7, 5'd0);
      checkOutput("bCollideNew", B_RD1, 32'h5555);

      applyStimulus(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0);
      checkOutput("bR0Old", B_RD1, 32'h0);
      checkOutput("bR0BusySame", B_BSY1, 32'h0);
      idle(5'd0, 5'd0);
      checkOutput("bR0Stored", B_RD1, 32'hFFFF);
      checkOutput("bR0Busy", B_BSY1, 32'h1);
      checkOutput("bR0Any", B_ANY, 32'h1);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h0123, 1'b0, 5'd0, 5'd0, 5'd0);
      checkOutput("bBusyRegd", B_BSY1, 32'h1);
      checkOutput("bOldData", B_RD1, 32'hFFFF);
      checkOutput("bAnyRegd", B_ANY, 32'h1);
      idle(5'd0, 5'd0);
      checkOutput("bBusyClr", B_BSY1, 32'h0);
      checkOutput("bAnyClr", B_ANY, 32'h0);
      checkOutput("bNewData", B_RD1, 32'h0123);

      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 5'(i + 8), {16'h0, pat[i]}, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
      end
      for (int i = 0; i < 8; i++) begin
         idle(5'(i), 5'(15 - i));
         checkOutput($sformatf("sweepRd1_%0d", i), B_RD1, {16'h0, pat[i]});
         checkOutput($sformatf("sweepRd2_%0d", 7 - i), B_RD2, {16'h0, pat[7 - i]});
      end

      idle(5'd0, 5'd0);
      @(posedge clk);
      #1 done = 1'b1;
   end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the MIPS datapath: two combinational read ports, two synchronous write ports, optional write-to-read bypass and a per-register busy scoreboard. It sits between decode (reads, destination issue) and writeback (ALU result and load return arrive on separate write ports). Register 0 is optionally hardwired to zero.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2^ADDR_W registers
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = read returns stored value
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset, asynchronous, active-low
- RdAddr1, RdAddr2  in  ADDR_W  read addresses
- RdData1, RdData2  out  DATA_W  read data (combinational)
- RdBusy1, RdBusy2  out  1  addressed register has a pending producer
- WrEn0, WrEn1  in  1  write enables; port 1 = load return, port 0 = ALU result
- WrAddr0, WrAddr1  in  ADDR_W  write addresses
- WrData0, WrData1  in  DATA_W  write data
- IssueEn  in  1  mark IssueAddr busy (decode issued an instruction writing it)
- IssueAddr  in  ADDR_W  destination register being issued
- AnyBusy  out  1  OR of all busy bits (drain indication)

## Operation
- Storage: 2^ADDR_W x DATA_W registers, busy[2^ADDR_W] bit vector.
- Write: on rising CLK, WrEnN writes WrDataN to WrAddrN. Both ports, same address: port 1 value stored, port 0 discarded. Different addresses: both written.
- ZERO_REG=1: writes to address 0 dropped; reads of 0 return 0 regardless of bypass; busy[0] stays 0 and IssueEn to 0 ignored.
- Read (BYPASS=1), priority per read port: address 0 with ZERO_REG -> 0; match WrAddr1 with WrEn1 -> WrData1; match WrAddr0 with WrEn0 -> WrData0; else stored value.
- Read (BYPASS=0): stored value (or 0 for reg 0 with ZERO_REG); new value visible the cycle after the write.
- Scoreboard next-state per register r: set if IssueEn and IssueAddr==r; else clear if any enabled write targets r; else hold. Issue wins over same-cycle writeback (new producer supersedes old).
- RdBusyN (BYPASS=1): busy[addr] AND NOT (enabled write to addr this cycle). BYPASS=0: busy[addr] registered value only.
- Same-cycle IssueEn to address being read does not affect RdBusy that cycle (takes effect next cycle).
- AnyBusy: OR of registered busy bits.
- No error reporting: write to a non-busy register is legal (plain write); double issue leaves busy set.

## Timing
- RST low (async, any time, including mid-write): all registers 0, all busy 0 immediately; RdData* = 0, RdBusy* = 0, AnyBusy = 0 while RST low. Writes and issues ignored while RST low.
- Write latency: 1 edge to storage; 0 cycles to read ports with BYPASS=1, 1 cycle with BYPASS=0.
- Busy set latency: visible on RdBusy/AnyBusy the cycle after IssueEn.
- Busy clear latency: 0 cycles on RdBusy with BYPASS=1, 1 cycle otherwise; AnyBusy always 1 cycle.
- Read paths purely combinational from addresses, write inputs and state; no read enable.

## Test plan
- Reset: load r5=0x1234, assert RST low mid-cycle -> RdData1(addr 5)=0, AnyBusy=0 at once; after release r5 still reads 0.
- Dual-port collision: WrEn0/WrEn1 both to r7, data 0xAAAA/0x5555 -> same-cycle read (BYPASS=1) 0x5555, next cycle stored 0x5555; BYPASS=0 build: same cycle old value, next cycle 0x5555.
- Zero register: write 0xFFFFFFFF to r0 via both ports, IssueEn to r0 -> RdData=0, RdBusy=0, AnyBusy=0 throughout (ZERO_REG=1); ZERO_REG=0 build reads 0xFFFFFFFF next cycle.
- Scoreboard: IssueEn r3 -> next cycle RdBusy1(r3)=1, AnyBusy=1; WrEn1 r3=0x42 -> same cycle RdBusy1=0, RdData1=0x42; next cycle AnyBusy=0.
- Issue/writeback race: busy[9]=1, same cycle WrEn0 r9 and IssueEn r9 -> next cycle busy[9]=1, stored r9 = written data.
- Parameter sweep: DATA_W=16, ADDR_W=3 -> write/read all 8 registers with distinct patterns, addresses wrap correctly, no aliasing.
